apb_master_ctrl: RTL
====================

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 15, max ACCESS cycles with PREADY low before abort (range 1..255).
REQ-002 Parameter: NSLV, 2, number of slave selects driven.
REQ-003 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 PRST  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  requester has a transfer pending.
REQ-006 req_ready  out  1  controller accepts the request this cycle.
REQ-007 req_write  in  1  1 = write, 0 = read.
REQ-008 req_addr  in  9  bit 8 = slave index, bits 7:0 = slave byte address.
REQ-009 req_wdata  in  8  write data.
REQ-010 PSEL  out  NSLV  one-hot slave select.
REQ-011 PENABLE, PWRITE  out  1 each  APB phase and direction.
REQ-012 padd, pwdata  out  8 each  APB address and write data.
REQ-013 PREADY  in  1  completion from the selected slave.
REQ-014 prdata  in  NSLV*8  per-slave read data; slice i belongs to PSEL[i].
REQ-015 rd_data  out  8  captured read data.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 err  out  1  valid with done; 1 = timeout abort.

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS.
REQ-019 req_ready SHALL be 1 only in IDLE; a transfer is accepted when req_valid && req_ready.
REQ-020 On accept, req_write, req_addr and req_wdata SHALL be registered; PWRITE, padd and pwdata SHALL hold those values, unchanged, until the transfer ends.
REQ-021 IDLE->SETUP on accept; SETUP->ACCESS unconditionally after 1 cycle.
REQ-022 SETUP: PSEL[req_addr[8]] = 1, PENABLE = 0. ACCESS: same PSEL, PENABLE = 1.
REQ-023 ACCESS with PREADY = 1: the transfer completes, next state is IDLE, PSEL and PENABLE go to 0 next cycle.
REQ-024 On a read completion, rd_data SHALL load the prdata slice of the selected slave. On a write completion or an abort, rd_data SHALL hold its value.
REQ-025 done SHALL pulse for exactly 1 cycle, in the cycle after completion or abort, with err valid in that same cycle.
REQ-026 Latency with zero wait states: accept at edge N, PSEL at N+1, PENABLE at N+2, done at N+3; next accept possible at N+3.
REQ-027 Wait counter (8 bit) SHALL clear on entry to ACCESS and increment on each ACCESS cycle with PREADY = 0.
REQ-028 When the wait counter reaches TIMEOUT while PREADY = 0, the transfer SHALL abort: go to IDLE, clear PSEL/PENABLE, done = 1 and err = 1 next cycle.
REQ-029 PREADY = 1 in the same cycle the counter reaches TIMEOUT SHALL count as a normal completion (err = 0).
REQ-030 req_valid outside IDLE SHALL be ignored; there is no queuing.
REQ-031 A PSEL index >= NSLV SHALL drive no select and SHALL abort after TIMEOUT cycles.
REQ-032 PREADY SHALL be ignored outside ACCESS.

Reset
REQ-033 PRST low SHALL force, asynchronously: state IDLE, PSEL = 0, PENABLE = 0, PWRITE = 0, padd = 0, pwdata = 0, rd_data = 0, done = 0, err = 0, wait counter = 0.
REQ-034 Reset mid-transfer SHALL drop the transfer silently, with no done pulse; req_ready = 1 from the first edge after PRST is released.

Structure
REQ-035 Shared package apb_pkg SHALL hold the FSM state enum, the address width (8), the data width (8) and the slave-index bit position (8).
REQ-036 One sub-module, apb_decoder, SHALL map the slave index to one-hot PSEL and mux prdata; the FSM and counter SHALL stay in the top module.

Verification
REQ-037 Write: addr 0x012, wdata 0xA5, PREADY tied 1 -> PSEL = 01 at N+1, PENABLE at N+2, done = 1 and err = 0 at N+3.
REQ-038 Read: addr 0x112, slave1 prdata = 0x3C -> PSEL = 10, rd_data = 0x3C at done.
REQ-039 Wait states: PREADY held low 3 ACCESS cycles -> PENABLE high for 4 cycles, padd and pwdata stable throughout, done with err = 0.
REQ-040 Timeout: TIMEOUT = 4, PREADY held 0 -> abort after 4 ACCESS cycles, done = 1, err = 1, rd_data unchanged.
REQ-041 Busy: req_valid held during a transfer with a different addr -> ignored until IDLE, then accepted as a second, separate transfer.
REQ-042 Reset: PRST low during ACCESS -> all outputs 0 immediately, no done pulse; a new request completes normally after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and widths for the APB master controller and its slave decoder.
package apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam int ADDR_W      = 8;
    localparam int DATA_W      = 8;
    localparam int SLV_IDX_BIT = 8;

endpackage

// File: rtl/apb_decoder.sv
// Maps the registered slave index to a one-hot PSEL and selects that slave's read data.
module apb_decoder
    import apb_pkg::*;
#(
    parameter int NSLV = 2
) (
    input  logic                     i_idx,
    input  logic [NSLV*DATA_W-1:0]   i_prdata,
    output logic [NSLV-1:0]          o_sel,
    output logic [DATA_W-1:0]        o_rdata
);

    // An index with no matching slave leaves every select low, so the
    // controller only ever leaves such a transfer through its timeout.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        o_sel   = '0;
        o_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (i == int'(i_idx)) begin
                o_sel[i] = 1'b1;
                o_rdata  = i_prdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// Single-request APB master: accepts one transfer in IDLE, runs SETUP/ACCESS,
// and reports completion or a wait-state timeout with a one-cycle done pulse.
module apb_master_ctrl
    import apb_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int NSLV    = 2
) (
    input  logic                     PCLK,
    input  logic                     PRST,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [SLV_IDX_BIT:0]     req_addr,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic [NSLV-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        padd,
    output logic [DATA_W-1:0]        pwdata,
    input  logic                     PREADY,
    input  logic [NSLV*DATA_W-1:0]   prdata,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     done,
    output logic                     err
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic                r_write;
    logic                r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rd_data;
    logic                r_done;
    logic                r_err;
    logic [7:0]          r_wait_cnt;

    logic                w_accept;
    logic                w_in_access;
    logic                w_complete;
    logic                w_abort;
    logic [NSLV-1:0]     w_sel;
    logic [DATA_W-1:0]   w_slv_rdata;

    apb_decoder #(
        .NSLV (NSLV)
    ) u_decoder (
        .i_idx    (r_idx),
        .i_prdata (prdata),
        .o_sel    (w_sel),
        .o_rdata  (w_slv_rdata)
    );

    assign w_accept    = req_valid && req_ready;
    assign w_in_access = (r_state == ST_ACCESS);
    assign w_complete  = w_in_access && PREADY;
    // Abort on the ACCESS cycle whose stall would bring the counter to TIMEOUT;
    // PREADY in that same cycle wins and the transfer completes normally.
    assign w_abort     = w_in_access && !PREADY && (r_wait_cnt == WAIT_LAST);

    always_ff @(posedge PCLK or negedge PRST) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!PRST) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_ACCESS;
            ST_ACCESS: if (w_complete || w_abort) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        unique case (r_state)
            ST_IDLE:   req_ready = 1'b1;
            ST_SETUP:  PSEL = w_sel;
            ST_ACCESS: begin
                PSEL    = w_sel;
                PENABLE = 1'b1;
            end
            default:   ;
        endcase
    end

    // Request fields are captured only on accept, so the APB address, data and
    // direction stay frozen for the whole transfer even if the requester moves on.
    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            r_write <= 1'b0;
            r_idx   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= req_write;
            r_idx   <= req_addr[SLV_IDX_BIT];
            r_addr  <= req_addr[ADDR_W-1:0];
            r_wdata <= req_wdata;
        end
    end

    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if (w_in_access && !PREADY) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge PCLK or negedge PRST) begin
        if (!PRST) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_done <= w_complete || w_abort;
            r_err  <= w_abort;
            if (w_complete && !r_write) r_rd_data <= w_slv_rdata;
        end
    end

    assign PWRITE  = r_write;
    assign padd    = r_addr;
    assign pwdata  = r_wdata;
    assign rd_data = r_rd_data;
    assign done    = r_done;
    assign err     = r_err;

endmodule
